dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the simple single-cycle MIPS core. It is the memory-side end of the request interface that the control unit drives for LW and SW. It accepts one word request at a time, models a fixed access latency, and returns read data or a write acknowledgement on a valid/ready response channel. Misaligned and out-of-range accesses return an error flag and have no side effects.

## Interface
Parameters:
- DEPTH_LOG2, 10: memory holds 2^DEPTH_LOG2 32-bit words.
- LATENCY, 2: cycles from request accept to first resp_val; legal range 1..15.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_val  in  1  request valid.
- req_rdy  out  1  responder can accept a request.
- req_rw  in  1  0 = read (mreq_r), 1 = write (mreq_w).
- req_addr  in  32  byte address.
- req_wdata  in  32  write data; ignored for reads.
- resp_val  out  1  response valid.
- resp_rdy  in  1  consumer accepts the response.
- resp_rdata  out  32  read data; 0 for writes and errors.
- resp_err  out  1  access was misaligned or out of range.

## Operation
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - req_rdy=1.
  - When req_val=1, capture rw, addr and wdata. Go to BUSY and load the countdown with LATENCY-1. If LATENCY=1, go directly to RESP.
- BUSY:
  - req_rdy=0.
  - Decrement the countdown each cycle. When it reaches 0, perform the access and go to RESP.
- Access rules, applied on the BUSY→RESP transition:
  - Error when addr[1:0]≠0 or addr[31:DEPTH_LOG2+2]≠0. On error, set resp_err=1 and resp_rdata=0, and do not write the array.
  - Read: resp_rdata = mem[addr[DEPTH_LOG2+1:2]].
  - Write: mem[index] = wdata and resp_rdata=0.
- RESP:
  - resp_val=1. resp_rdata and resp_err hold stable until resp_rdy=1.
  - When resp_rdy=1, go to IDLE. req_rdy rises the following cycle, so there is no same-cycle re-accept.
- Reset mid-operation: abandon any in-flight request and return to IDLE. A write that has not yet reached RESP is not performed. Array contents are not reset.
- req_val in BUSY or RESP is ignored. The requester must hold the request until it sees req_rdy.

## Timing
- Outputs during reset and in the first cycle after it: req_rdy=0, resp_val=0, resp_rdata=0, resp_err=0. req_rdy=1 from the second cycle after reset deasserts.
- A request accepted at edge T gives resp_val=1 in the cycle after edge T+LATENCY-1. That is, resp_val is high exactly LATENCY cycles after the accept cycle.
- Minimum request spacing is LATENCY+2 cycles with resp_rdy tied high.
- Write-then-read to the same word returns the new data.
- All outputs come from registers. There is no combinational path from req_* or resp_rdy to any output.

## Structure
- Shared package mem_pkg:
  - mreq_r=1'b0 and mreq_w=1'b1.
  - The state encoding constants IDLE=2'd0, BUSY=2'd1, RESP=2'd2.
  - The function is_word_aligned. The control unit reuses the mreq constants.
- One sub-module, dmem_array: single-port synchronous RAM, 32-bit words, 2^DEPTH_LOG2 entries, with write enable, index, wdata and registered rdata.
- dmem_responder holds the FSM, the countdown, the request capture registers and the error check.

## Test plan
- Write then read, LATENCY=2, resp_rdy=1:
  - SW addr 0x10, data 0xDEADBEEF → resp_val two cycles after accept, resp_err=0, resp_rdata=0.
  - Then LW addr 0x10 → resp_rdata=0xDEADBEEF.
- Misaligned access: LW addr 0x13 → resp_err=1, resp_rdata=0.
- Out of range: SW addr 0x1000 with DEPTH_LOG2=10 → resp_err=1. A later LW of word 0 returns its prior value, unchanged.
- Backpressure:
  - Hold resp_rdy=0 for 5 cycles → resp_val, resp_rdata and resp_err stay stable and req_rdy=0 throughout.
  - resp_rdy=1 → IDLE next cycle.
- Reset in BUSY: SW addr 0x20, data 0x1234, reset asserted one cycle after accept → all outputs 0. A later LW of 0x20 returns the old contents.
- LATENCY=1 build: back-to-back LW → resp_val the cycle after each accept, accepts spaced 3 cycles apart.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared memory-request encodings, responder states and alignment helper
package mem_pkg;

    localparam logic mreq_r = 1'b0;
    localparam logic mreq_w = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    function automatic logic is_word_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word RAM with registered, clearable read data
module dmem_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  we,
    input  logic                  clr,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem_q [2**DEPTH_LOG2];
    logic [31:0] rdata_q;

    // Contents are deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[idx] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            rdata_q <= '0;
        end else if (en) begin
            rdata_q <= we ? 32'd0 : mem_q[idx];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - fixed-latency data-memory responder with valid/ready request and response
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_val,
    output logic        req_rdy,
    input  logic        req_rw,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    dmem_state_t state_q;
    logic [3:0]  cnt_q;
    logic        rw_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        req_rdy_q;
    logic        resp_val_q;
    logic        resp_err_q;

    logic        accept;
    logic        access;
    logic        leave;
    logic        acc_rw;
    logic        acc_err;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    // With LATENCY=1 the access happens on the accept edge, so the live request is used.
    always_comb begin
        accept    = (state_q == IDLE) && req_rdy_q && req_val;
        leave     = (state_q == RESP) && resp_rdy;
        acc_rw    = (state_q == IDLE) ? req_rw    : rw_q;
        acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        acc_err   = !is_word_aligned(acc_addr) || ((acc_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
        access    = !reset && ((accept && (LATENCY == 1)) ||
                               ((state_q == BUSY) && (cnt_q == 4'd1)));
    end

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (access && !acc_err),
        .we    (acc_rw == mreq_w),
        .clr   (!reset && ((access && acc_err) || leave)),
        .idx   (acc_addr[DEPTH_LOG2+1:2]),
        .wdata (acc_wdata),
        .rdata (resp_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            rw_q       <= mreq_r;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            req_rdy_q  <= 1'b0;
            resp_val_q <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_rdy_q <= 1'b1;
                    if (accept) begin
                        rw_q      <= req_rw;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        req_rdy_q <= 1'b0;
                        if (LATENCY == 1) begin
                            state_q    <= RESP;
                            resp_val_q <= 1'b1;
                            resp_err_q <= acc_err;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q    <= RESP;
                        resp_val_q <= 1'b1;
                        resp_err_q <= acc_err;
                    end
                end
                RESP: begin
                    if (resp_rdy) begin
                        state_q    <= IDLE;
                        resp_val_q <= 1'b0;
                        resp_err_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_rdy  = req_rdy_q;
    assign resp_val = resp_val_q;
    assign resp_err = resp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder at LATENCY 2 and 1
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req_val = 2'b00;
    logic [1:0]  req_rdy;
    logic [1:0]  req_rw = 2'b00;
    logic [1:0]  resp_val;
    logic [1:0]  resp_rdy = 2'b11;
    logic [1:0]  resp_err;
    logic [31:0] req_addr0 = '0, req_addr1 = '0;
    logic [31:0] req_wdata0 = '0, req_wdata1 = '0;
    logic [31:0] resp_rdata0, resp_rdata1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_acc [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(2)) dut_l2 (
        .clk(clk), .reset(reset),
        .req_val(req_val[0]), .req_rdy(req_rdy[0]), .req_rw(req_rw[0]),
        .req_addr(req_addr0), .req_wdata(req_wdata0),
        .resp_val(resp_val[0]), .resp_rdy(resp_rdy[0]),
        .resp_rdata(resp_rdata0), .resp_err(resp_err[0])
    );

    dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .req_val(req_val[1]), .req_rdy(req_rdy[1]), .req_rw(req_rw[1]),
        .req_addr(req_addr1), .req_wdata(req_wdata1),
        .resp_val(resp_val[1]), .resp_rdy(resp_rdy[1]),
        .resp_rdata(resp_rdata1), .resp_err(resp_err[1])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdata_of(input int d);
        return (d == 0) ? resp_rdata0 : resp_rdata1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_rdy"}, {30'd0, req_rdy}, 32'd0);
        chk({tag, "_resp_val"}, {30'd0, resp_val}, 32'd0);
        chk({tag, "_resp_err"}, {30'd0, resp_err}, 32'd0);
        chk({tag, "_rdata0"}, resp_rdata0, 32'd0);
        chk({tag, "_rdata1"}, resp_rdata1, 32'd0);
    endtask

    // One request on DUT d, checking latency, response, optional backpressure and return to idle.
    task automatic do_req(input int d, input logic rw, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold, input int exp_gap);
        int n = 0;
        int lat = (d == 0) ? 2 : 1;
        while (!req_rdy[d] && n < 20) begin
            tick();
            n++;
        end
        chk("req_rdy_before_accept", {31'd0, req_rdy[d]}, 32'd1);
        req_val[d] = 1'b1;
        req_rw[d]  = rw;
        if (d == 0) begin
            req_addr0 = addr; req_wdata0 = wdata;
        end else begin
            req_addr1 = addr; req_wdata1 = wdata;
        end
        tick();
        req_val[d] = 1'b0;
        if (exp_gap != 0) chk("accept_gap", cyc - last_acc[d], exp_gap);
        last_acc[d] = cyc;
        chk("req_rdy_after_accept", {31'd0, req_rdy[d]}, 32'd0);
        for (int i = 1; i < lat; i++) begin
            chk("resp_val_busy", {31'd0, resp_val[d]}, 32'd0);
            tick();
        end
        chk("resp_val", {31'd0, resp_val[d]}, 32'd1);
        chk("resp_rdata", rdata_of(d), exp_rdata);
        chk("resp_err", {31'd0, resp_err[d]}, {31'd0, exp_err});
        if (hold > 0) begin
            resp_rdy[d] = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                chk("bp_resp_val", {31'd0, resp_val[d]}, 32'd1);
                chk("bp_resp_rdata", rdata_of(d), exp_rdata);
                chk("bp_resp_err", {31'd0, resp_err[d]}, {31'd0, exp_err});
                chk("bp_req_rdy", {31'd0, req_rdy[d]}, 32'd0);
            end
            resp_rdy[d] = 1'b1;
        end
        tick();
        chk("idle_resp_val", {31'd0, resp_val[d]}, 32'd0);
        chk("idle_req_rdy_low", {31'd0, req_rdy[d]}, 32'd0);
        tick();
        chk("idle_req_rdy_high", {31'd0, req_rdy[d]}, 32'd1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        tick();
        tick();
        chk_all_zero("in_reset");
        reset = 1'b0;
        tick();
        chk("post_reset_rdy0", {30'd0, req_rdy}, 32'd3);

        // LATENCY=2 directed sequence
        do_req(0, 1'b1, 32'h0000_0000, 32'h0000_0A5A, 32'd0, 1'b0, 0, 0);
        do_req(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, 4);
        do_req(0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 0, 4);
        do_req(0, 1'b0, 32'h0000_0013, 32'd0, 32'd0, 1'b1, 0, 4);
        do_req(0, 1'b1, 32'h0000_1000, 32'h5555_5555, 32'd0, 1'b1, 0, 4);
        do_req(0, 1'b0, 32'h0000_0000, 32'd0, 32'h0000_0A5A, 1'b0, 0, 4);
        do_req(0, 1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 5, 0);
        do_req(0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'd0, 1'b0, 0, 0);

        // Write abandoned by reset while in BUSY
        n = 0;
        while (!req_rdy[0] && n < 20) begin
            tick();
            n++;
        end
        chk("rst_busy_rdy", {31'd0, req_rdy[0]}, 32'd1);
        req_val[0] = 1'b1; req_rw[0] = 1'b1;
        req_addr0 = 32'h0000_0020; req_wdata0 = 32'h0000_1234;
        tick();
        req_val[0] = 1'b0;
        reset = 1'b1;
        tick();
        chk_all_zero("rst_busy");
        reset = 1'b0;
        tick();
        chk("rst_busy_rdy_back", {30'd0, req_rdy}, 32'd3);
        do_req(0, 1'b0, 32'h0000_0020, 32'd0, 32'hCAFE_F00D, 1'b0, 0, 0);

        // LATENCY=1 back-to-back
        do_req(1, 1'b1, 32'h0000_0040, 32'h1111_1111, 32'd0, 1'b0, 0, 0);
        do_req(1, 1'b1, 32'h0000_0044, 32'h2222_2222, 32'd0, 1'b0, 0, 3);
        do_req(1, 1'b0, 32'h0000_0040, 32'd0, 32'h1111_1111, 1'b0, 0, 3);
        do_req(1, 1'b0, 32'h0000_0044, 32'd0, 32'h2222_2222, 1'b0, 0, 3);
        do_req(1, 1'b0, 32'h0000_0042, 32'd0, 32'd0, 1'b1, 0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
